fx3_slave_fifo_rx: RTL and testbench
====================================

// Module: fx3_slave_fifo_rx
// PURPOSE
//  FX3 synchronous slave-FIFO read engine: drains an FX3 producer socket (FX3->FPGA) into a valid/ready stream.
//  Counterpart of the FPGA->FX3 write path; both share DQ/ADDR/SLCS via the top-level bus arbiter.
//  Handles FX3 read-data and flag latency with credit accounting and an internal skid FIFO.
// PARAMETERS
//  DW            32  data width (matches DQ)
//  RD_LATENCY    2   cycles from SLRD_N sampled low to word valid on DQ_IN
//  FLAG_LATENCY  3   cycles from ADDR change / read to flags reflecting it
//  SKID_DEPTH    8   skid FIFO entries, power of 2, >= RD_LATENCY+FLAG_LATENCY
// PORTS
//  CLK100        in   1   100 MHz interface clock (same clock as CLK_OUT to FX3)
//  RESET         in   1   synchronous, active-high reset
//  EN            in   1   level: keep draining while high
//  SOCKET        in   2   FX3 socket address, sampled on IDLE->ADDR_WAIT
//  BUS_REQ       out  1   request for shared FX3 bus
//  BUS_GNT       in   1   grant from arbiter
//  ADDR          out  2   FX3 FIFO address
//  SLCS_N        out  1   chip select, active low
//  SLOE_N        out  1   output enable, active low; top tristates DQ driver while low
//  SLRD_N        out  1   read strobe, active low
//  DQ_IN         in   DW  DQ input path
//  FLAG_EMPTY_N  in   1   FLAGC: 0 = socket empty
//  FLAG_PEMPTY_N in   1   FLAGD: 0 = <= watermark words remain
//  OUT_DATA      out  DW  stream data
//  OUT_VALID     out  1   stream valid
//  OUT_READY     in   1   stream ready
// BEHAVIOUR
//  Reset: SLCS_N=SLOE_N=SLRD_N=1, ADDR=0, BUS_REQ=0, OUT_VALID=0, OUT_DATA=0, skid flushed, in-flight cleared.
//  States: IDLE, REQ, ADDR_WAIT, OE_SETUP, BURST, SINGLE, SINGLE_WAIT, DRAIN.
//  IDLE: EN=1 -> REQ, BUS_REQ=1. REQ: BUS_GNT=1 -> ADDR_WAIT, ADDR<=SOCKET, SLCS_N=0.
//  ADDR_WAIT: hold FLAG_LATENCY cycles (flags ignored) -> OE_SETUP; SLOE_N=0 for exactly 1 cycle before any SLRD.
//  OE_SETUP -> BURST.
//  BURST: SLRD_N=0 iff PEMPTY_N=1 and credit ok; PEMPTY_N=0 & EMPTY_N=1 -> SINGLE; EMPTY_N=0 -> DRAIN.
//  SINGLE: one-cycle SLRD_N=0 (if credit ok) -> SINGLE_WAIT; holds FLAG_LATENCY cycles, then re-evaluate as BURST.
//  Credit ok: skid_count + inflight + 1 <= SKID_DEPTH; otherwise SLRD_N=1 that cycle, state held.
//  Capture: RD_LATENCY-deep shift of issued reads; on exit DQ_IN is pushed; overflow impossible by credit.
//  Stop: EN=0 or BUS_GNT=0 in any active state -> SLRD_N=1 immediately -> DRAIN.
//  DRAIN: wait inflight==0, then SLOE_N=1, SLCS_N=1, BUS_REQ=0 same cycle -> IDLE. Skid contents retained and delivered.
//  Stream: OUT_DATA/OUT_VALID held stable until OUT_READY; push and pop same cycle allowed; output order = FX3 order.
//  Simultaneous EN=0 and last word in flight: word captured, then IDLE. Reset mid-burst: in-flight words discarded.
//  FX3 firmware requirement: socket watermark >= FLAG_LATENCY words.
// CONFIGURATION
//  FX3_RX_STATS_EN defined: adds outputs RX_WORDS[31:0] (wrapping count of pushed words, reset 0) and
//  RX_STALL (sticky, set when a read was withheld for lack of credit, cleared by RESET).
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  fx3_pkg: state enum, FX3 flag polarity constants, default latencies.
//  Sub-module fx3_rx_skid_fifo: SKID_DEPTH x DW sync FIFO with count, first-word-fall-through output.
// TESTING
//  1 Model: 20 words, PEMPTY at 4; OUT_READY=1 -> 20 words in order, SLOE_N low 1 cycle before first SLRD_N.
//  2 OUT_READY=0 during burst -> SLRD_N stops at skid full (8), no loss; ready=1 resumes, all words delivered.
//  3 3 words only (PEMPTY_N=0 at start) -> SINGLE path, SLRD pulses >= FLAG_LATENCY+1 apart, exactly 3 words.
//  4 EN=0 mid-burst with 2 in flight -> both words delivered, then SLCS_N/SLOE_N high, BUS_REQ=0.
//  5 BUS_GNT dropped mid-burst -> SLRD_N=1 next cycle, DRAIN, IDLE; RESET mid-burst -> all outputs reset next cycle.
//  6 With FX3_RX_STATS_EN, case 2 -> RX_WORDS=20, RX_STALL=1.

Source files
------------

// File: rtl/fx3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx3_pkg
// Purpose  : Shared types and constants for the FX3 slave-FIFO read engine.
//            Read-engine state encoding, FX3 flag polarity, and default
//            latency and sizing values used as parameter defaults.
// Revision : 1.0  initial release
// ============================================================================
package fx3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_ADDR_WAIT   = 3'd2,
    ST_OE_SETUP    = 3'd3,
    ST_BURST       = 3'd4,
    ST_SINGLE      = 3'd5,
    ST_SINGLE_WAIT = 3'd6,
    ST_DRAIN       = 3'd7
  } rx_state_e;

  // FX3 flags are active low: the asserted level means "empty" / "partially empty".
  localparam logic FX3_FLAG_EMPTY  = 1'b0;
  localparam logic FX3_FLAG_PEMPTY = 1'b0;

  localparam int DEF_DW           = 32;
  localparam int DEF_RD_LATENCY   = 2;
  localparam int DEF_FLAG_LATENCY = 3;
  localparam int DEF_SKID_DEPTH   = 8;

endpackage : fx3_pkg
`default_nettype wire

// File: rtl/fx3_rx_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fx3_rx_skid_fifo
// Purpose  : Synchronous DEPTH x DW FIFO with occupancy count and
//            first-word-fall-through output. Absorbs words still arriving
//            from FX3 after the read strobe has been withdrawn.
// Ports    : clk_i, rst_i (sync, active high)
//            push_i/push_data_i  write side (caller guarantees no overflow)
//            pop_i               consume head word (ignored when empty)
//            data_o/valid_o      head word, zero while empty
//            count_o             current occupancy
// Revision : 1.0  initial release
// ============================================================================
module fx3_rx_skid_fifo
  import fx3_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_SKID_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          w_pop;

  assign w_pop = pop_i && (count_q != '0);

  // Storage needs no reset: entries are only observable once written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule : fx3_rx_skid_fifo
`default_nettype wire

// File: rtl/fx3_slave_fifo_rx.sv
`default_nettype none
// ============================================================================
// Module   : fx3_slave_fifo_rx
// Purpose  : FX3 synchronous slave-FIFO read engine. Drains an FX3 producer
//            socket into a valid/ready stream, tracking read-data and flag
//            latency with credit accounting against an internal skid FIFO.
// Ports    : CLK100, RESET (sync, active high), EN, SOCKET
//            BUS_REQ/BUS_GNT       shared FX3 bus arbitration
//            ADDR, SLCS_N, SLOE_N, SLRD_N, DQ_IN, FLAG_EMPTY_N, FLAG_PEMPTY_N
//                                  FX3 slave-FIFO interface
//            OUT_DATA/OUT_VALID/OUT_READY  output stream
// Options  : FX3_RX_STATS_EN adds RX_WORDS (wrapping pushed-word count) and
//            RX_STALL (sticky: a read was withheld for lack of credit).
// Revision : 1.0  initial release
// ============================================================================
module fx3_slave_fifo_rx
  import fx3_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int FLAG_LATENCY = DEF_FLAG_LATENCY,
  parameter int SKID_DEPTH   = DEF_SKID_DEPTH
) (
  input  logic          CLK100,
  input  logic          RESET,
  input  logic          EN,
  input  logic [1:0]    SOCKET,
  output logic          BUS_REQ,
  input  logic          BUS_GNT,
  output logic [1:0]    ADDR,
  output logic          SLCS_N,
  output logic          SLOE_N,
  output logic          SLRD_N,
  input  logic [DW-1:0] DQ_IN,
  input  logic          FLAG_EMPTY_N,
  input  logic          FLAG_PEMPTY_N,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY
`ifdef FX3_RX_STATS_EN
  ,output logic [31:0]  RX_WORDS
  ,output logic         RX_STALL
`endif
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;

  rx_state_e             state_q, state_d;
  logic [1:0]            addr_q, addr_d;
  logic [7:0]            wait_q, wait_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;

  logic [CW-1:0] w_skid_count;
  int            w_inflight;
  logic          w_credit_ok;
  logic          w_stop;
  logic          w_empty;
  logic          w_pempty;
  logic          w_want_rd;
  logic          w_rd;
  logic          w_drain_done;
  logic          w_push;
  logic          w_pop;
  logic          w_cs_active;
  logic          w_oe_active;

  assign w_empty  = (FLAG_EMPTY_N == FX3_FLAG_EMPTY);
  assign w_pempty = (FLAG_PEMPTY_N == FX3_FLAG_PEMPTY);
  assign w_stop   = !EN || !BUS_GNT;

  // A read may only be issued if the word it returns is guaranteed a skid
  // slot, counting every word still travelling through the read pipeline.
  assign w_inflight  = $countones(rd_pipe_q);
  assign w_credit_ok = (int'(w_skid_count) + w_inflight + 1) <= SKID_DEPTH;
  assign w_rd        = w_want_rd && w_credit_ok;

  always_ff @(posedge CLK100) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wait_q    <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      rd_pipe_q <= (rd_pipe_q << 1) | RD_LATENCY'(w_rd);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wait_d       = wait_q;
    w_want_rd    = 1'b0;
    w_drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (BUS_GNT) begin
          state_d = ST_ADDR_WAIT;
          addr_d  = SOCKET;
          wait_d  = '0;
        end
      end
      // Flags are stale right after an address change; wait them out.
      ST_ADDR_WAIT: begin
        if (w_stop)                                 state_d = ST_DRAIN;
        else if (wait_q == 8'(FLAG_LATENCY - 1))    state_d = ST_OE_SETUP;
        else                                        wait_d  = wait_q + 8'd1;
      end
      ST_OE_SETUP: begin
        state_d = w_stop ? ST_DRAIN : ST_BURST;
      end
      ST_BURST: begin
        if (w_stop || w_empty)  state_d   = ST_DRAIN;
        else if (w_pempty)      state_d   = ST_SINGLE;
        else                    w_want_rd = 1'b1;
      end
      // Near empty: one word at a time, then let the flags catch up.
      ST_SINGLE: begin
        if (w_stop || w_empty) begin
          state_d = ST_DRAIN;
        end else begin
          w_want_rd = 1'b1;
          if (w_credit_ok) begin
            state_d = ST_SINGLE_WAIT;
            wait_d  = '0;
          end
        end
      end
      ST_SINGLE_WAIT: begin
        if (w_stop)                                 state_d = ST_DRAIN;
        else if (wait_q == 8'(FLAG_LATENCY - 1))    state_d = ST_BURST;
        else                                        wait_d  = wait_q + 8'd1;
      end
      // Keep the bus until every issued read has returned its word.
      ST_DRAIN: begin
        if (w_inflight == 0) begin
          w_drain_done = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_cs_active = (state_q inside {ST_ADDR_WAIT, ST_OE_SETUP, ST_BURST,
                                        ST_SINGLE, ST_SINGLE_WAIT, ST_DRAIN});
  assign w_oe_active = (state_q inside {ST_OE_SETUP, ST_BURST, ST_SINGLE,
                                        ST_SINGLE_WAIT, ST_DRAIN});

  assign BUS_REQ = (state_q != ST_IDLE) && !w_drain_done;
  assign SLCS_N  = !(w_cs_active && !w_drain_done);
  assign SLOE_N  = !(w_oe_active && !w_drain_done);
  assign SLRD_N  = !w_rd;
  assign ADDR    = addr_q;

  assign w_push = rd_pipe_q[RD_LATENCY-1];
  assign w_pop  = OUT_VALID && OUT_READY;

  fx3_rx_skid_fifo #(
    .DW    (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk_i       (CLK100),
    .rst_i       (RESET),
    .push_i      (w_push),
    .push_data_i (DQ_IN),
    .pop_i       (w_pop),
    .data_o      (OUT_DATA),
    .valid_o     (OUT_VALID),
    .count_o     (w_skid_count)
  );

`ifdef FX3_RX_STATS_EN
  logic [31:0] rx_words_q;
  logic        rx_stall_q;

  always_ff @(posedge CLK100) begin
    if (RESET) begin
      rx_words_q <= '0;
      rx_stall_q <= 1'b0;
    end else begin
      if (w_push) rx_words_q <= rx_words_q + 32'd1;
      if (w_want_rd && !w_credit_ok) rx_stall_q <= 1'b1;
    end
  end

  assign RX_WORDS = rx_words_q;
  assign RX_STALL = rx_stall_q;
`else
  // Statistics counters are not built.
`endif

endmodule : fx3_slave_fifo_rx
`default_nettype wire

// File: tb/tb_fx3_slave_fifo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx3_slave_fifo_rx
// Purpose  : Self-checking bench for fx3_slave_fifo_rx. A behavioural FX3
//            socket (word queue, delayed flags, delayed read data) feeds the
//            engine; every strobed word is expected on the stream in order.
// Revision : 1.0  initial release
// ============================================================================
module tb_fx3_slave_fifo_rx;

  localparam int DW    = 32;
  localparam int RDL   = 2;
  localparam int FL    = 3;
  localparam int DEPTH = 8;
  localparam int WM    = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET = 1'b1;
  logic          EN = 1'b0;
  logic [1:0]    SOCKET = 2'd0;
  logic          BUS_REQ;
  logic          BUS_GNT = 1'b0;
  logic [1:0]    ADDR;
  logic          SLCS_N, SLOE_N, SLRD_N;
  logic [DW-1:0] DQ_IN = '0;
  logic          FLAG_EMPTY_N = 1'b0;
  logic          FLAG_PEMPTY_N = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
`ifdef FX3_RX_STATS_EN
  logic [31:0]   RX_WORDS;
  logic          RX_STALL;
`endif

  fx3_slave_fifo_rx #(
    .DW(DW), .RD_LATENCY(RDL), .FLAG_LATENCY(FL), .SKID_DEPTH(DEPTH)
  ) dut (
    .CLK100(clk), .RESET(RESET), .EN(EN), .SOCKET(SOCKET),
    .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT), .ADDR(ADDR),
    .SLCS_N(SLCS_N), .SLOE_N(SLOE_N), .SLRD_N(SLRD_N), .DQ_IN(DQ_IN),
    .FLAG_EMPTY_N(FLAG_EMPTY_N), .FLAG_PEMPTY_N(FLAG_PEMPTY_N),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef FX3_RX_STATS_EN
    , .RX_WORDS(RX_WORDS), .RX_STALL(RX_STALL)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // FX3 socket model and stream scoreboard
  logic [31:0] sock_q[$];
  logic [31:0] exp_q[$];
  int          hist[FL];
  logic [31:0] st_w = '0;
  bit          st_v = 1'b0;
  bit          last_rd = 1'b0, last_valid = 1'b0, last_ready = 1'b0, last_rst = 1'b1;
  bit          prev_oe_n = 1'b1;
  logic [31:0] last_data = '0;
  bit          en_v = 1'b0, gnt_v = 1'b1, rst_v = 1'b1;
  int          ready_mode = 0;
  logic [1:0]  cur_sock = 2'd0;
  int          cyc = 0, n_reads = 0, n_pops = 0, min_gap = 1000, last_rd_cyc = -1, run = 0;

  task automatic step();
    int          fc;
    logic [31:0] w;
    @(posedge clk);
    #1;
    cyc++;
    w = $urandom();
    // Effects of the edge just passed.
    if (last_rst) begin
      exp_q.delete();
    end else if (last_valid && last_ready) begin
      check_val("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val("stream_data", last_data, exp_q.pop_front());
      n_pops++;
    end
    if (last_rd) begin
      check_val("rd_nonempty", 32'(sock_q.size() != 0), 32'd1);
      if (sock_q.size() != 0) begin
        w = sock_q.pop_front();
        n_reads++;
        if (last_rd_cyc >= 0 && (cyc - last_rd_cyc) < min_gap) min_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
        if (!last_rst) exp_q.push_back(w);
      end
    end
    // Read data appears RD_LATENCY edges after the strobe was sampled.
    DQ_IN = st_v ? st_w : $urandom();
    st_v  = last_rd && !last_rst;
    st_w  = w;
    // Flags reflect the socket level FLAG_LATENCY cycles late.
    fc = hist[FL-1];
    for (int i = FL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sock_q.size();
    FLAG_EMPTY_N  = (fc > 0);
    FLAG_PEMPTY_N = (fc > WM);
    EN      = en_v;
    BUS_GNT = gnt_v;
    RESET   = rst_v;
    SOCKET  = cur_sock;
    OUT_READY = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (!SLRD_N) begin
      check_val("rd_cs_oe_setup", {29'd0, SLCS_N, SLOE_N, prev_oe_n}, 32'd0);
      check_val("rd_addr", {30'd0, ADDR}, {30'd0, cur_sock});
      check_val("rd_en_gnt", {30'd0, EN, BUS_GNT}, 32'd3);
    end
    if (last_valid && !last_ready && !last_rst) begin
      check_val("hold_valid", {31'd0, OUT_VALID}, 32'd1);
      check_val("hold_data", OUT_DATA, last_data);
    end
    last_rd    = !SLRD_N;
    last_valid = OUT_VALID;
    last_ready = OUT_READY;
    last_data  = OUT_DATA;
    last_rst   = RESET;
    prev_oe_n  = SLOE_N;
    run        = last_rd ? run + 1 : 0;
  endtask

  task automatic do_reset(input string tag);
    rst_v = 1'b1;
    step();
    step();
    check_val({tag, "_rst_ctl"}, {25'd0, BUS_REQ, SLCS_N, SLOE_N, SLRD_N, OUT_VALID, ADDR}, 32'b0111000);
    check_val({tag, "_rst_data"}, OUT_DATA, 32'd0);
    rst_v = 1'b0;
  endtask

  task automatic new_socket(input int n, input logic [1:0] s);
    sock_q.delete();
    for (int i = 0; i < n; i++) sock_q.push_back($urandom());
    for (int i = 0; i < FL; i++) hist[i] = n;
    cur_sock = s;
    n_reads = 0; n_pops = 0; min_gap = 1000; last_rd_cyc = -1; run = 0;
  endtask

  task automatic wait_delivered(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (sock_q.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    check_val({tag, "_left"}, 32'(sock_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic go_idle(input string tag);
    en_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!BUS_REQ && SLCS_N && SLOE_N && exp_q.size() == 0) break;
    end
    check_val({tag, "_idle"}, {29'd0, BUS_REQ, SLCS_N, SLOE_N}, 32'd3);
    check_val({tag, "_idle_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_run(input int len, input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (run >= len) break;
    end
    check_val({tag, "_reads_seen"}, 32'(run >= len), 32'd1);
  endtask

  initial begin
    // 1: full burst, always ready
    do_reset("s1");
    new_socket(20, 2'd1); ready_mode = 0; en_v = 1'b1; gnt_v = 1'b1;
    wait_delivered(400, "s1");
    check_val("s1_pops", 32'(n_pops), 32'd20);
    check_val("s1_reads", 32'(n_reads), 32'd20);
    go_idle("s1");

    // 2: consumer stalled -> reads stop when skid credit runs out
    do_reset("s2");
    new_socket(20, 2'd2); ready_mode = 1; en_v = 1'b1;
    repeat (60) step();
    check_val("s2_reads_at_full", 32'(n_reads), 32'(DEPTH));
    check_val("s2_valid_held", {31'd0, OUT_VALID}, 32'd1);
    ready_mode = 0;
    wait_delivered(400, "s2");
    check_val("s2_pops", 32'(n_pops), 32'd20);
`ifdef FX3_RX_STATS_EN
    check_val("s2_rx_words", RX_WORDS, 32'd20);
    check_val("s2_rx_stall", {31'd0, RX_STALL}, 32'd1);
`endif
    go_idle("s2");

    // 3: below watermark from the start -> single reads spaced by flag latency
    do_reset("s3");
    new_socket(3, 2'd0); ready_mode = 2; en_v = 1'b1;
    wait_delivered(400, "s3");
    check_val("s3_pops", 32'(n_pops), 32'd3);
    check_val("s3_gap_ok", 32'(min_gap >= FL + 1), 32'd1);
    go_idle("s3");

    // 4: EN dropped with two reads in flight
    do_reset("s4");
    new_socket(30, 2'd3); ready_mode = 0; en_v = 1'b1;
    wait_run(2, "s4");
    en_v = 1'b0;
    step();
    check_val("s4_rd_stop", {31'd0, SLRD_N}, 32'd1);
    go_idle("s4");
    check_val("s4_delivered", 32'(n_pops), 32'(n_reads));
    check_val("s4_min_reads", 32'(n_reads >= 2), 32'd1);

    // 5a: grant withdrawn mid-burst
    do_reset("s5");
    new_socket(30, 2'd1); ready_mode = 2; en_v = 1'b1;
    wait_run(1, "s5a");
    gnt_v = 1'b0;
    step();
    check_val("s5_rd_stop", {31'd0, SLRD_N}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (SLCS_N && SLOE_N) break;
      step();
    end
    check_val("s5_bus_released", {30'd0, SLCS_N, SLOE_N}, 32'd3);
    gnt_v = 1'b1;
    wait_delivered(800, "s5a");
    check_val("s5a_pops", 32'(n_pops), 32'd30);
    go_idle("s5a");

    // 5b: reset in the middle of a burst, then recover
    new_socket(30, 2'd2); ready_mode = 2; en_v = 1'b1;
    wait_run(2, "s5b");
    do_reset("s5b");
    wait_delivered(800, "s5b");
    go_idle("s5b");

    // Randomised sockets, sizes and back-pressure
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 40);
      do_reset("rnd");
      new_socket(n, 2'($urandom_range(0, 3))); ready_mode = 2; en_v = 1'b1;
      wait_delivered(2000, "rnd");
      check_val("rnd_pops", 32'(n_pops), 32'(n));
      go_idle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fx3_slave_fifo_rx
`default_nettype wire
